// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage Mips pipeline: EX/MEM/WB
// scoreboard, stall/flush generation, forwarding selects, stall counter.
// Optional feature macro: HAZARD_FWD_EN (forwarding with load-use stall only).
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_wsel,
    input  logic              id_regw,
    input  logic              id_memr,
    input  logic              id_jump,
    input  logic              ex_br_taken,
    input  logic              cnt_clr,
    output logic              stall,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wsel;
        logic              regw;
        logic              memr;
    } sb_entry_t;

    sb_entry_t         ex_r;
    sb_entry_t         mem_r;
    sb_entry_t         wb_r;
    logic [REG_AW-1:0] ex_rs_r;
    logic [REG_AW-1:0] ex_rt_r;
    logic              ex_use_rs_r;
    logic              ex_use_rt_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              ex_hit_s;
    logic              mem_hit_s;
    logic              hazard_s;
    logic              unused_s;

    function automatic logic is_writer(input sb_entry_t e);
        return e.valid & e.regw & (e.wsel != {REG_AW{1'b0}});
    endfunction

    function automatic logic id_reads(input sb_entry_t e, input logic [REG_AW-1:0] rs,
                                      input logic [REG_AW-1:0] rt, input logic use_rs,
                                      input logic use_rt);
        return is_writer(e) & ((use_rs & (rs == e.wsel)) | (use_rt & (rt == e.wsel)));
    endfunction

    // MEM beats WB; a load still in MEM has no data yet, so it cannot forward.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input sb_entry_t m, input sb_entry_t w);
        logic [1:0] sel;
        if (src == {REG_AW{1'b0}}) begin
            sel = 2'b00;
        end else if (is_writer(m) && !m.memr && (m.wsel == src)) begin
            sel = 2'b01;
        end else if (is_writer(w) && (w.wsel == src)) begin
            sel = 2'b10;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection, stall/flush and forwarding selects.
    always_comb begin
        ex_hit_s  = id_reads(ex_r, id_rs, id_rt, id_use_rs, id_use_rt);
        mem_hit_s = id_reads(mem_r, id_rs, id_rt, id_use_rs, id_use_rt);
`ifdef HAZARD_FWD_EN
        hazard_s  = id_valid & ex_hit_s & ex_r.memr;
        fwd_a     = fwd_sel(ex_rs_r, mem_r, wb_r);
        fwd_b     = fwd_sel(ex_rt_r, mem_r, wb_r);
`else
        // WB is not checked: the register file is write-through.
        hazard_s  = id_valid & (ex_hit_s | mem_hit_s);
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
`endif
        stall      = hazard_s & ~ex_br_taken;
        flush_ifid = ex_br_taken | (id_jump & id_valid & ~stall);
    end

    // Scoreboard fields that only one build configuration consumes.
    assign unused_s = ^{ex_use_rs_r, ex_use_rt_r, ex_rs_r, ex_rt_r, ex_r.memr, mem_r.memr, wb_r};

    // Scoreboard shift: WB <= MEM <= EX, EX takes ID or becomes a bubble.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ex_r        <= '0;
            mem_r       <= '0;
            wb_r        <= '0;
            ex_rs_r     <= {REG_AW{1'b0}};
            ex_rt_r     <= {REG_AW{1'b0}};
            ex_use_rs_r <= 1'b0;
            ex_use_rt_r <= 1'b0;
        end else begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (id_valid && !stall && !ex_br_taken) begin
                ex_r.valid  <= 1'b1;
                ex_r.wsel   <= id_wsel;
                ex_r.regw   <= id_regw;
                ex_r.memr   <= id_memr;
                ex_rs_r     <= id_rs;
                ex_rt_r     <= id_rt;
                ex_use_rs_r <= id_use_rs;
                ex_use_rt_r <= id_use_rt;
            end else begin
                ex_r.valid  <= 1'b0;
            end
        end
    end

    // Saturating stall counter; clear has priority over increment.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (stall && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign stall_cnt = cnt_r;

endmodule
